// File: rtl/div_pkg.sv
// Shared definitions for the mantissa divider.
//   MANT_W  : default fraction width of each operand
//   Q_W     : quotient width (hidden bit + fraction + guard + one extra bit for the <1.0 case)
//   state_e : divider control states
//   CMP_*   : result codes of the magnitude comparator
package div_pkg;

    localparam int unsigned MANT_W = 23;
    localparam int unsigned Q_W    = MANT_W + 3;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        NORM,
        DONE
    } state_e;

    localparam logic [1:0] CMP_GT = 2'b10;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_EQ = 2'b00;

endpackage

// File: rtl/mant_cmp.sv
// Combinational unsigned 3-way magnitude compare.
//   a, b : operands (W bits)
//   code : CMP_GT when a > b, CMP_LT when a < b, CMP_EQ when equal
module mant_cmp
    import div_pkg::*;
#(
    parameter int unsigned W = 25
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [1:0]   code
);

    always_comb begin
        code = CMP_EQ;
        if (a > b) begin
            code = CMP_GT;
        end else if (a < b) begin
            code = CMP_LT;
        end
    end

endmodule

// File: rtl/mant_div_seq.sv
// Sequential restoring divider for the FPU division path, one quotient bit per clock.
//   clk, rst            : clock, synchronous active-high reset
//   start, ready        : operand handshake (start sampled only while ready)
//   a_mant, b_mant      : dividend / divisor fractions (hidden 1 restored internally)
//   out_valid, out_ready: result handshake
//   mant, guard, sticky : normalized quotient mantissa and rounding bits
//   exp_dec             : quotient was below 1.0, exponent must be decremented
module mant_div_seq #(
    parameter int unsigned MANT_W = div_pkg::MANT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [MANT_W-1:0] b_mant,
    output logic              ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W:0]   mant,
    output logic              guard,
    output logic              sticky,
    output logic              exp_dec
);
    import div_pkg::*;

    localparam int unsigned QW = MANT_W + 3;
    localparam int unsigned DW = MANT_W + 1;
    localparam int unsigned RW = MANT_W + 2;
    localparam logic [4:0]  LAST_BIT = 5'(QW - 1);

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [RW-1:0]     r_q, r_d;
    logic [DW-1:0]     d_q, d_d;
    logic [QW-1:0]     q_q, q_d;
    logic [MANT_W:0]   mant_d;
    logic              guard_d, sticky_d, exp_dec_d;

    logic [1:0]        cmp_code;
    logic              sub;
    logic [RW-1:0]     diff;

    mant_cmp #(
        .W (RW)
    ) u_cmp (
        .a    (r_q),
        .b    ({1'b0, d_q}),
        .code (cmp_code)
    );

    // Illegal code 2'b11 falls through to "no subtract", i.e. treated as LT.
    assign sub  = (cmp_code == CMP_GT) || (cmp_code == CMP_EQ);
    assign diff = r_q - {1'b0, d_q};

    // Gated by rst so ready is low for the whole reset pulse.
    assign ready     = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        d_d       = d_q;
        q_d       = q_q;
        mant_d    = mant;
        guard_d   = guard;
        sticky_d  = sticky;
        exp_dec_d = exp_dec;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    r_d     = {1'b0, 1'b1, a_mant};
                    d_d     = {1'b1, b_mant};
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                q_d = {q_q[QW-2:0], sub};
                // R stays below 2*D, so the shifted value always fits in RW bits.
                r_d = sub ? {diff[RW-2:0], 1'b0} : {r_q[RW-2:0], 1'b0};
                if (cnt_q == LAST_BIT) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            NORM: begin
                if (q_q[QW-1]) begin
                    mant_d    = q_q[QW-1:2];
                    guard_d   = q_q[1];
                    sticky_d  = q_q[0] | (r_q != '0);
                    exp_dec_d = 1'b0;
                end else begin
                    mant_d    = q_q[QW-2:1];
                    guard_d   = q_q[0];
                    sticky_d  = (r_q != '0);
                    exp_dec_d = 1'b1;
                end
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            d_q     <= '0;
            q_q     <= '0;
            mant    <= '0;
            guard   <= 1'b0;
            sticky  <= 1'b0;
            exp_dec <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            d_q     <= d_d;
            q_q     <= q_d;
            mant    <= mant_d;
            guard   <= guard_d;
            sticky  <= sticky_d;
            exp_dec <= exp_dec_d;
        end
    end

endmodule
